// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Round-robin arbiter/sequencer that shares one external memory/IO bus
// between NREQ internal requesters (0 = fetch, 1 = data, 2 = debug).
// It latches the winning requester's transaction and drives it onto the
// bus with a valid/ready handshake. It then returns the read data and
// pulses done to the owner.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a bus wait after
// TIMEOUT stalled cycles. The aborted transaction completes with
// rdata = all ones and err pulses together with done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ena                 design enable; low freezes all state and outputs
//   req, req_we         per-requester request level and write enable
//   req_addr, req_wdata packed per-requester address / write data
//   gnt                 one-hot grant, high while that requester owns the bus
//   done, err           one-cycle completion / timeout pulse to the owner
//   rdata               read data from the last completion
//   busy                high while a transaction is in ISSUE or DONE
//   bus_*               shared-bus request side (valid, we, addr, wdata)
//   bus_ready, bus_rdata shared-bus response side
module cpu_bus_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic               bus_valid,
    output logic               bus_we,
    output logic [AW-1:0]      bus_addr,
    output logic [DW-1:0]      bus_wdata,
    input  logic               bus_ready,
    input  logic [DW-1:0]      bus_rdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [AW-1:0]     bus_addr_q, bus_addr_d;
    logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
`endif

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [IW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr_ptr_q) + 32'(k)) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; everything holds while ena is low.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = done_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_d          = ST_ISSUE;
                        gnt_d            = '0;
                        gnt_d[win_idx]   = 1'b1;
                        owner_d          = win_idx;
                        busy_d           = 1'b1;
                        bus_valid_d      = 1'b1;
                        bus_we_d         = req_we[win_idx];
                        bus_addr_d       = req_addr[32'(win_idx)*AW +: AW];
                        bus_wdata_d      = req_wdata[32'(win_idx)*DW +: DW];
`ifdef ARB_TIMEOUT_EN
                        cnt_d            = '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (bus_ready) begin
                        state_d     = ST_DONE;
                        rdata_d     = bus_rdata;
                        bus_valid_d = 1'b0;
                        gnt_d       = '0;
                        done_d      = gnt_q;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT)) begin
                        // Bus never answered: complete with an error.
                        state_d     = ST_DONE;
                        rdata_d     = '1;
                        bus_valid_d = 1'b0;
                        gnt_d       = '0;
                        done_d      = gnt_q;
                        err_d       = gnt_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    state_d  = ST_IDLE;
                    done_d   = '0;
                    err_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset wins over ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule
